// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing stages: sample width,
// default image geometry, pooling state encoding and signed helpers.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int IMG_W_DEF = 24;
  localparam int IMG_H_DEF = 24;

  typedef logic signed [DATA_W-1:0] sample_t;

  // S_FILL: even row, horizontal pair maxima go into the row buffer
  // S_POOL: odd row, pair maxima combine with the buffer into one output
  typedef enum logic {
    S_FILL = 1'b0,
    S_POOL = 1'b1
  } pool_state_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic sample_t relu(input sample_t a);
    return a[DATA_W-1] ? '0 : a;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Half-width row buffer holding the horizontal pair maxima of the even row.
// Synchronous write, asynchronous read; contents are not reset because every
// entry is written in the even row before the odd row reads it.
module pool_row_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF / 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store one pair maximum per accepted odd-column sample of the even row
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + 2x2 stride-2 max pooling on a raster-order conv result stream.
// Optional feature: define RELU_EN to clamp negative samples to zero before
// pooling; without it the pooling is raw signed max.
//
// state  | meaning
// S_FILL | even row: pair maxima written to the row buffer, no output
// S_POOL | odd row: pair maxima merged with buffer, one output per window
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  pool_state_t       state_q, state_d;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  sample_t           h_reg, v_in, hmax, buf_rdata;
  logic [DATA_W-1:0] buf_rdata_raw;
  logic [BW-1:0]     buf_addr;
  logic              accept, col_odd, col_last, row_last;
  logic              buf_we, win_done, out_xfer, out_last;

  // Single output register: a new sample may enter whenever the register is
  // free or is being drained in the same cycle.
  assign in_ready = rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~clr;
  assign out_xfer = out_valid & out_ready;

`ifdef RELU_EN
  assign v_in = relu(sample_t'(in_data));
`else
  assign v_in = sample_t'(in_data);
`endif

  assign col_odd   = col[0];
  assign col_last  = (col == COL_MAX);
  assign row_last  = (row == ROW_MAX);
  assign hmax      = smax(h_reg, v_in);
  assign buf_addr  = BW'(col >> 1);
  assign buf_rdata = sample_t'(buf_rdata_raw);

  pool_row_buf #(
    .DEPTH (IMG_W / 2),
    .AW    (BW)
  ) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (hmax),
    .raddr (buf_addr),
    .rdata (buf_rdata_raw)
  );

  // State register; clr restarts the frame in the fill phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state_q <= S_FILL;
    else if (clr) state_q <= S_FILL;
    else          state_q <= state_d;
  end

  // Next state flips at every row end; buffer write vs window completion by phase
  always_comb begin
    state_d  = state_q;
    buf_we   = 1'b0;
    win_done = 1'b0;
    case (state_q)
      S_FILL: begin
        buf_we = accept & col_odd;
        if (accept && col_last) state_d = S_POOL;
      end
      S_POOL: begin
        win_done = accept & col_odd;
        if (accept && col_last) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  // Raster counters and the left-sample holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      h_reg <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (!col_odd) h_reg <= v_in;
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output register with hold-until-accepted handshake and end-of-frame pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_xfer & out_last;
      if (win_done) begin
        out_data  <= smax(buf_rdata, hmax);
        out_valid <= 1'b1;
        out_last  <= row_last & col_last;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: a small 4x2 instance for directed cases and a
// 24x24 instance for two random back-to-back frames. A frame-array model
// predicts every pooled value and the frame_done pulse.
module tb_relu_maxpool;

  typedef logic signed [15:0] s16_t;
  typedef struct packed {
    logic signed [15:0] d;
    logic               last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr0, clr1, in_valid0, in_valid1, out_ready0, out_ready1;
  logic [15:0] in_data0, in_data1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic        frame_done0, frame_done1;
  logic [15:0] out_data0, out_data1;
  bit          rnd_bp = 1'b0;

  exp_t expq [2][$];
  s16_t outlog [2][$];
  s16_t pix [2][24][24];
  int   mcol [2];
  int   mrow [2];
  bit   exp_fd [2];
  int   fdcnt [2];
  int   checks = 0;
  int   errors = 0;

  relu_maxpool #(.IMG_W(4), .IMG_H(2)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .frame_done(frame_done0)
  );

  relu_maxpool #(.IMG_W(24), .IMG_H(24)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int img_w(input int k);
    return (k == 0) ? 4 : 24;
  endfunction

  function automatic int img_h(input int k);
    return (k == 0) ? 2 : 24;
  endfunction

  // Checks one instance at the falling edge, then applies what the coming
  // rising edge will do (output transfer, clr, sample acceptance) to the model.
  task automatic model_step(input int k, input logic cl, input logic iv,
                            input logic [15:0] id, input logic ir, input logic ov,
                            input logic [15:0] od, input logic ordy, input logic fd);
    bit   nfd;
    s16_t v, m, x;
    exp_t e;
    if (!rst) begin
      chk($sformatf("d%0d_rst_out_valid", k), ov, 0);
      chk($sformatf("d%0d_rst_out_data", k), $signed(od), 0);
      chk($sformatf("d%0d_rst_in_ready", k), ir, 0);
      mcol[k] = 0;
      mrow[k] = 0;
      expq[k].delete();
      exp_fd[k] = 1'b0;
    end else begin
      chk($sformatf("d%0d_in_ready", k), ir, (!ov || ordy) ? 1 : 0);
      chk($sformatf("d%0d_frame_done", k), fd, exp_fd[k]);
      if (fd === 1'b1) fdcnt[k]++;
      chk($sformatf("d%0d_out_valid", k), ov, (expq[k].size() != 0) ? 1 : 0);
      if (ov === 1'b1 && expq[k].size() != 0)
        chk($sformatf("d%0d_out_data", k), $signed(od), expq[k][0].d);
      nfd = 1'b0;
      if (ov === 1'b1 && ordy) begin
        outlog[k].push_back(s16_t'(od));
        if (expq[k].size() != 0) begin
          nfd = expq[k][0].last;
          void'(expq[k].pop_front());
        end
      end
      if (cl) begin
        nfd = 1'b0;
        expq[k].delete();
        mcol[k] = 0;
        mrow[k] = 0;
      end else if (iv && ir === 1'b1) begin
        v = s16_t'(id);
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        pix[k][mrow[k]][mcol[k]] = v;
        if (mrow[k] % 2 == 1 && mcol[k] % 2 == 1) begin
          m = pix[k][mrow[k]-1][mcol[k]-1];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              x = pix[k][mrow[k]-1+dr][mcol[k]-1+dc];
              if (x > m) m = x;
            end
          e.d    = m;
          e.last = (mrow[k] == img_h(k) - 1) && (mcol[k] == img_w(k) - 1);
          expq[k].push_back(e);
        end
        if (mcol[k] == img_w(k) - 1) begin
          mcol[k] = 0;
          mrow[k] = (mrow[k] == img_h(k) - 1) ? 0 : mrow[k] + 1;
        end else begin
          mcol[k] = mcol[k] + 1;
        end
      end
      exp_fd[k] = nfd;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, clr0, in_valid0, in_data0, in_ready0, out_valid0, out_data0,
               out_ready0, frame_done0);
    model_step(1, clr1, in_valid1, in_data1, in_ready1, out_valid1, out_data1,
               out_ready1, frame_done1);
  end

  initial begin
    out_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready1 = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [15:0] v);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    if (k == 0) begin in_valid0 = 1'b1; in_data0 = v; end
    else        begin in_valid1 = 1'b1; in_data1 = v; end
    while (!done) begin
      @(negedge clk);
      if (((k == 0) ? in_ready0 : in_ready1) === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout d%0d: in_ready low for %0d cycles, required accept", k, n);
        done = 1'b1;
      end
    end
    if (k == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  task automatic send_frame0(input int a0, input int a1, input int a2, input int a3,
                             input int a4, input int a5, input int a6, input int a7,
                             input int cnt);
    int fr[8];
    fr = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < cnt; i++) send(0, 16'(fr[i]));
  endtask

  initial begin
    int n;
    clr0 = 1'b0; clr1 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_data0 = '0; in_data1 = '0;
    out_ready0 = 1'b1;
    for (int k = 0; k < 2; k++) begin fdcnt[k] = 0; exp_fd[k] = 1'b0; end

    // reset state and mid-stream reset
    cycles(3);
    @(negedge clk);
    chk("t1_rst_out_valid", out_valid0, 0);
    chk("t1_rst_out_data", $signed(out_data0), 0);
    chk("t1_rst_in_ready", in_ready0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    send(0, 16'(1)); send(0, 16'(5)); send(0, 16'(-3));
    rst = 1'b0;
    @(negedge clk);
    chk("t1_mid_in_ready", in_ready0, 0);
    chk("t1_mid_out_valid", out_valid0, 0);
    cycles(2);
    rst = 1'b1;

    // basic frame
    outlog[0].delete(); fdcnt[0] = 0;
    send_frame0(1, 5, -3, 2, 4, 0, 7, -8, 8);
    cycles(4);
    chk("t2_count", outlog[0].size(), 2);
    chk("t2_win0", outlog[0][0], 5);
    chk("t2_win1", outlog[0][1], 7);
    chk("t2_frame_done", fdcnt[0], 1);

    // all-negative frame
    outlog[0].delete(); fdcnt[0] = 0;
    send_frame0(-9, -2, -4, -7, -3, -5, -1, -6, 8);
    cycles(4);
    chk("t3_count", outlog[0].size(), 2);
`ifdef RELU_EN
    chk("t3_win0", outlog[0][0], 0);
    chk("t3_win1", outlog[0][1], 0);
`else
    chk("t3_win0", outlog[0][0], -2);
    chk("t3_win1", outlog[0][1], -1);
`endif
    chk("t3_frame_done", fdcnt[0], 1);

    // backpressure on the first output
    outlog[0].delete(); fdcnt[0] = 0;
    out_ready0 = 1'b0;
    send_frame0(1, 5, -3, 2, 4, 0, 7, -8, 6);
    in_valid0 = 1'b1;
    in_data0  = 16'(7);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid0, 1);
      chk("t4_hold_data", $signed(out_data0), 5);
      chk("t4_hold_in_ready", in_ready0, 0);
    end
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    send(0, 16'(7));
    send(0, 16'(-8));
    cycles(4);
    chk("t4_count", outlog[0].size(), 2);
    chk("t4_win0", outlog[0][0], 5);
    chk("t4_win1", outlog[0][1], 7);
    chk("t4_frame_done", fdcnt[0], 1);

    // clr with a pending output
    outlog[0].delete(); fdcnt[0] = 0;
    out_ready0 = 1'b0;
    send_frame0(1, 5, -3, 2, 4, 0, 7, -8, 6);
    clr0 = 1'b1;
    in_valid0 = 1'b1;
    in_data0  = 16'h1234;
    @(posedge clk); #1;
    clr0 = 1'b0;
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("t5_drop_valid", out_valid0, 0);
    chk("t5_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    send_frame0(10, -1, 6, 6, -20, 3, -5, 9, 8);
    cycles(4);
    chk("t5_count", outlog[0].size(), 2);
    chk("t5_win0", outlog[0][0], 10);
    chk("t5_win1", outlog[0][1], 9);
    chk("t5_frame_done", fdcnt[0], 1);

    // two back-to-back random 24x24 frames with gaps and backpressure
    outlog[1].delete(); fdcnt[1] = 0;
    rnd_bp = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 576; i++) begin
        if ($urandom_range(0, 3) == 0) cycles(1);
        send(1, 16'($urandom));
      end
    rnd_bp = 1'b0;
    n = 0;
    cycles(2);
    while (out_valid1 === 1'b1 && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(3);
    chk("t6_count", outlog[1].size(), 288);
    chk("t6_frame_done", fdcnt[1], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
